// File: rtl/mips_loader_pkg.sv
// ============================================================================
//  mips_loader_pkg : shared types and header-field constants for the loader
//  Revision 1.0
// ============================================================================
`default_nettype none

package mips_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        BASE   = 3'd2,
        DATA   = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } loader_state_t;

    localparam int   HDR_TARGET_BIT = 31;
    localparam int   HDR_COUNT_MSB  = 15;
    localparam int   HDR_COUNT_LSB  = 0;

    localparam logic TARGET_IMEM = 1'b0;
    localparam logic TARGET_DMEM = 1'b1;

endpackage

`default_nettype wire

// File: rtl/program_loader_mips.sv
// ============================================================================
//  program_loader_mips : boot-time segment loader feeding the MIPS imem/dmem
//  write ports and holding the pipeline in reset until loading completes.
//  Revision 1.0
// ============================================================================
`default_nettype none

module program_loader_mips
    import mips_loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clock,
    input  logic                     resetMachine,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_last,
    output logic                     imem_we,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0]    imem_wdata,
    output logic                     dmem_we,
    output logic [ADDRESS_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0]    dmem_wdata,
    output logic                     cpu_hold,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam int CNT_W = HDR_COUNT_MSB - HDR_COUNT_LSB + 1;
    localparam int SUM_W = ADDRESS_WIDTH + 17;

    loader_state_t            state;
    loader_state_t            state_next;
    logic [CNT_W-1:0]         remaining;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic                     target;
    logic                     err_flag;

    logic                     accept;
    logic [CNT_W-1:0]         hdr_count;
    logic [SUM_W-1:0]         seg_end;
    logic                     overflow;
    logic                     set_err;
    logic                     clr_err;
    logic                     load_hdr;
    logic                     load_base;
    logic                     write_word;

    assign accept    = in_valid & in_ready;
    assign hdr_count = in_data[HDR_COUNT_MSB:HDR_COUNT_LSB];

    // Segment end is checked without wrap so a segment cannot run off the top of memory
    assign seg_end   = SUM_W'(in_data[ADDRESS_WIDTH-1:0]) + SUM_W'(remaining);
    assign overflow  = seg_end > (SUM_W'(1) << ADDRESS_WIDTH);

    always_ff @(posedge clock or negedge resetMachine) begin
        if (!resetMachine) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        set_err    = 1'b0;
        clr_err    = 1'b0;
        load_hdr   = 1'b0;
        load_base  = 1'b0;
        write_word = 1'b0;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_next = HEADER;
                    clr_err    = 1'b1;
                end
            end
            HEADER: begin
                if (accept) begin
                    if (hdr_count == '0) begin
                        // Terminator without in_last still finishes, but flagged
                        state_next = DONE;
                        set_err    = ~in_last;
                    end else if (in_last) begin
                        state_next = ERROR;
                        set_err    = 1'b1;
                    end else begin
                        state_next = BASE;
                        load_hdr   = 1'b1;
                    end
                end
            end
            BASE: begin
                if (accept) begin
                    if (in_last || overflow) begin
                        state_next = ERROR;
                        set_err    = 1'b1;
                    end else begin
                        state_next = DATA;
                        load_base  = 1'b1;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    if (in_last) begin
                        state_next = ERROR;
                        set_err    = 1'b1;
                    end else begin
                        write_word = 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            state_next = HEADER;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == HEADER) || (state == BASE) || (state == DATA);
        busy     = in_ready;
        done     = (state == DONE);
        error    = err_flag;
        cpu_hold = ~((state == DONE) && !err_flag);
    end

    always_ff @(posedge clock or negedge resetMachine) begin
        if (!resetMachine) begin
            remaining  <= '0;
            wr_addr    <= '0;
            target     <= TARGET_IMEM;
            err_flag   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            dmem_we <= 1'b0;

            if (clr_err) begin
                err_flag <= 1'b0;
            end else if (set_err) begin
                err_flag <= 1'b1;
            end

            if (load_hdr) begin
                remaining <= hdr_count;
                target    <= in_data[HDR_TARGET_BIT];
            end

            if (load_base) begin
                wr_addr <= in_data[ADDRESS_WIDTH-1:0];
            end

            // Only the selected port moves; the other keeps its last address/data
            if (write_word) begin
                wr_addr   <= wr_addr + ADDRESS_WIDTH'(1);
                remaining <= remaining - CNT_W'(1);
                if (target == TARGET_DMEM) begin
                    dmem_we    <= 1'b1;
                    dmem_addr  <= wr_addr;
                    dmem_wdata <= in_data;
                end else begin
                    imem_we    <= 1'b1;
                    imem_addr  <= wr_addr;
                    imem_wdata <= in_data;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_program_loader_mips.sv
// ============================================================================
//  tb_program_loader_mips : scoreboard bench with a stream-level reference model
//  Revision 1.0
// ============================================================================
`default_nettype none

module tb_program_loader_mips;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          resetMachine = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          error;

    program_loader_mips #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock        (clock),
        .resetMachine (resetMachine),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic          dm;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] s_data[$];
    logic        s_last[$];
    int          checks = 0;
    int          passes = 0;
    int          write_count = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clock) begin
        if (resetMachine && (imem_we || dmem_we)) begin
            wr_t act;
            wr_t e;
            write_count++;
            checks++;
            act.dm   = dmem_we;
            act.addr = dmem_we ? dmem_addr : imem_addr;
            act.data = dmem_we ? dmem_wdata : imem_wdata;
            if (imem_we && dmem_we) begin
                $display("FAIL dual_strobe: actual imem_we=1 dmem_we=1 required one");
            end else if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: actual dm=%0d addr=%0h data=%0h required none",
                         act.dm, act.addr, act.data);
            end else begin
                e = exp_q.pop_front();
                if (act === e) passes++;
                else $display("FAIL write: actual dm=%0d addr=%0h data=%0h required dm=%0d addr=%0h data=%0h",
                              act.dm, act.addr, act.data, e.dm, e.addr, e.data);
            end
        end
    end

    // Stream interpreter: walks the word list by the segment rules and records
    // the writes it implies, where the session stops and how it ends.
    task automatic model(output int used, output bit m_done, output bit m_err);
        int p = 0;
        bit stop = 0;
        m_done = 0;
        m_err  = 0;
        while (!stop) begin
            int          n;
            int          base;
            logic [31:0] hdr;
            hdr = s_data[p];
            n   = int'(hdr[15:0]);
            if (n == 0) begin
                m_done = 1;
                m_err  = !s_last[p];
                p++;
                break;
            end
            if (s_last[p]) begin m_err = 1; p++; break; end
            p++;
            base = int'(s_data[p][AW-1:0]);
            if (s_last[p] || (base + n > (1 << AW))) begin m_err = 1; p++; break; end
            p++;
            for (int i = 0; i < n; i++) begin
                if (s_last[p]) begin m_err = 1; p++; stop = 1; break; end
                exp_q.push_back('{dm: hdr[31], addr: AW'(base + i), data: s_data[p]});
                p++;
            end
        end
        used = p;
    endtask

    task automatic push_word(logic [31:0] d, bit l);
        s_data.push_back(d);
        s_last.push_back(l);
    endtask

    task automatic do_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("ready_after_start", in_ready, 1);
    endtask

    task automatic send_stream(int used, int gap_pct, int start_idx);
        for (int i = 0; i < used; i++) begin
            int waited = 0;
            @(negedge clock);
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                start    = 1'b0;
                @(negedge clock);
            end
            in_valid = 1'b1;
            in_data  = s_data[i];
            in_last  = s_last[i];
            start    = (i == start_idx);
            while (!in_ready && waited < 50) begin
                @(negedge clock);
                waited++;
            end
            if (!in_ready) begin
                checks++;
                $display("FAIL handshake_timeout: actual in_ready=0 required 1 at word %0d", i);
                break;
            end
            @(posedge clock);
        end
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic run_session(string tag, int gap_pct, int start_idx);
        int used;
        bit md;
        bit me;
        model(used, md, me);
        do_start();
        send_stream(used, gap_pct, start_idx);
        repeat (3) @(negedge clock);
        check({tag, "_drained"},  exp_q.size(), 0);
        check({tag, "_done"},     done, md);
        check({tag, "_error"},    error, me);
        check({tag, "_cpu_hold"}, cpu_hold, (!md || me));
        check({tag, "_busy"},     busy, 0);
        check({tag, "_in_ready"}, in_ready, 0);
    endtask

    task automatic build_load_program();
        s_data.delete();
        s_last.delete();
        push_word(32'h0000_0010, 0);
        push_word(32'h0000_0000, 0);
        for (int i = 0; i < 16; i++) push_word($urandom, 0);
        push_word(32'h8000_000B, 0);
        push_word(32'h0000_0000, 0);
        for (int i = 0; i < 11; i++) begin
            if (i == 8)       push_word(32'h8F02_F214, 0);
            else if (i == 10) push_word(32'hC0CA_C01A, 0);
            else              push_word($urandom, 0);
        end
        push_word(32'h0000_0000, 1);
    endtask

    task automatic build_random();
        int nseg;
        s_data.delete();
        s_last.delete();
        nseg = $urandom_range(1, 3);
        for (int s = 0; s < nseg; s++) begin
            int n;
            int kind;
            int base;
            int last_at;
            n    = $urandom_range(1, 6);
            kind = $urandom_range(0, 9);
            if (kind == 0) base = (1 << AW) - n + $urandom_range(0, 3);
            else           base = $urandom_range(0, (1 << AW) - n);
            if (base > (1 << AW) - 1) base = (1 << AW) - 1;
            last_at = (kind == 1) ? $urandom_range(0, n - 1) : -1;
            push_word({1'($urandom_range(0, 1)), 15'($urandom), 16'(n)}, 0);
            push_word(32'(base), 0);
            for (int i = 0; i < n; i++) push_word($urandom, i == last_at);
        end
        push_word({1'($urandom_range(0, 1)), 15'($urandom), 16'h0000}, $urandom_range(0, 4) != 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        int wc0;

        // Reset values
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_busy_done_error", {busy, done, error}, 0);
        check("rst_we", {imem_we, dmem_we}, 0);
        check("rst_addr_data", {imem_addr, dmem_addr, imem_wdata[15:0], dmem_wdata[15:0]}, 0);
        @(negedge clock);
        resetMachine = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_hold", {cpu_hold, busy, in_ready}, 3'b100);

        // Load algorithm: 27 writes then release
        build_load_program();
        wc0 = write_count;
        run_session("load", 0, -1);
        check("load_write_count", write_count - wc0, 27);

        // Back-pressure on the same stream
        build_load_program();
        run_session("backpressure", 40, -1);

        // start pulsed inside DATA is ignored
        build_load_program();
        run_session("start_in_data", 0, 6);

        // Overflow: base 0xFE with 4 words
        s_data.delete(); s_last.delete();
        push_word(32'h0000_0004, 0);
        push_word(32'h0000_00FE, 0);
        for (int i = 0; i < 4; i++) push_word($urandom, 0);
        push_word(32'h0, 1);
        run_session("overflow", 0, -1);

        // Exact fit at the top of memory is legal
        s_data.delete(); s_last.delete();
        push_word(32'h8000_0004, 0);
        push_word(32'h0000_00FC, 0);
        for (int i = 0; i < 4; i++) push_word($urandom, 0);
        push_word(32'h0, 1);
        run_session("top_fit", 0, -1);

        // Early in_last on the 3rd data word of 5
        s_data.delete(); s_last.delete();
        push_word(32'h0000_0005, 0);
        push_word(32'h0000_0010, 0);
        for (int i = 0; i < 5; i++) push_word($urandom, i == 2);
        run_session("early_last", 0, -1);

        // Terminator without in_last: done with error
        s_data.delete(); s_last.delete();
        push_word(32'h0000_0001, 0);
        push_word(32'h0000_0003, 0);
        push_word($urandom, 0);
        push_word(32'h0000_0000, 0);
        run_session("term_no_last", 0, -1);

        // Reset after two data words
        s_data.delete(); s_last.delete();
        push_word(32'h0000_0005, 0);
        push_word(32'h0000_0020, 0);
        for (int i = 0; i < 5; i++) push_word($urandom, 0);
        exp_q.push_back('{dm: 1'b0, addr: 8'h20, data: s_data[2]});
        exp_q.push_back('{dm: 1'b0, addr: 8'h21, data: s_data[3]});
        do_start();
        send_stream(4, 0, -1);
        #2;
        resetMachine = 1'b0;
        #1;
        check("midrst_ready_busy_done_error", {in_ready, busy, done, error}, 0);
        check("midrst_hold_we", {cpu_hold, imem_we, dmem_we}, 3'b100);
        check("midrst_addr", {imem_addr, imem_wdata}, 0);
        @(negedge clock);
        resetMachine = 1'b1;
        repeat (3) @(negedge clock);
        check("midrst_drained", exp_q.size(), 0);
        build_load_program();
        run_session("reload", 0, -1);

        // Randomized sessions
        for (int r = 0; r < 8; r++) begin
            build_random();
            run_session("random", $urandom_range(0, 50), -1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
